// File: rtl/dac_reg_feeder.sv
// Register-side producer for DAC_Interface: holds PS writes as pending values and publishes them via fresh_bits/read_resps.
// Ungated indices publish 1 edge after the write; gated ones wait for consumer_rdy. wr_ready never deasserts outside reset.
module dac_reg_feeder #(
  parameter int MEM_SIZE      = 12,
  parameter int DATA_WIDTH    = 16,
  parameter int SEED_BASE_ID  = 2,
  parameter int SEED_WORDS    = 4,
  parameter int SEED_VALID_ID = 6,
  parameter int RUN_PWL_ID    = 7
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [$clog2(MEM_SIZE)-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic                                 consumer_rdy,
  output logic [MEM_SIZE-1:0]                  fresh_bits,
  output logic [MEM_SIZE-1:0][DATA_WIDTH-1:0]  read_resps,
  output logic                                 ovr_pulse,
  output logic                                 err_pulse
);

  function automatic logic [MEM_SIZE-1:0] idx_mask(input bit seeds_only);
    logic [MEM_SIZE-1:0] m;
    m = '0;
    for (int i = 0; i < MEM_SIZE; i++) begin
      if (i >= SEED_BASE_ID && i < SEED_BASE_ID + SEED_WORDS) m[i] = 1'b1;
      if (!seeds_only && (i == SEED_VALID_ID || i == RUN_PWL_ID)) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [MEM_SIZE-1:0] SEED_MASK  = idx_mask(1'b1);
  localparam logic [MEM_SIZE-1:0] GATED_MASK = idx_mask(1'b0);
  localparam logic [MEM_SIZE-1:0] SV_MASK    = MEM_SIZE'(1) << SEED_VALID_ID;

  typedef enum logic {SEED_OPEN = 1'b0, SEED_HOLD = 1'b1} seed_state_e;

  seed_state_e                          state_q, state_d;
  logic                                 wr_ready_q;
  logic                                 ovr_q, ovr_d, err_q, err_d;
  logic [MEM_SIZE-1:0]                  pend_q, pend_d;
  logic [MEM_SIZE-1:0][DATA_WIDTH-1:0]  shadow_q, shadow_d, resp_q, resp_d;
  logic [MEM_SIZE-1:0]                  fresh, rel_v, wr_hit;
  logic                                 wr_acc, wr_in_range, seed_busy;

  assign wr_acc      = wr_valid && wr_ready_q;
  assign wr_in_range = (int'(wr_addr) < MEM_SIZE);
  assign wr_hit      = (wr_acc && wr_in_range) ? (MEM_SIZE'(1) << wr_addr) : '0;

  // The commit index stays hidden while any seed word it covers is still in flight.
  assign fresh     = pend_q & ~((state_q == SEED_HOLD) ? SV_MASK : '0);
  assign rel_v     = (GATED_MASK & fresh & {MEM_SIZE{consumer_rdy}}) | (~GATED_MASK & pend_q);
  assign seed_busy = |((pend_q | wr_hit) & SEED_MASK);

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEED_OPEN: if (seed_busy)  state_d = SEED_HOLD;
      SEED_HOLD: if (!seed_busy) state_d = SEED_OPEN;
      default:                   state_d = SEED_OPEN;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    resp_d   = resp_q;
    // A release publishes the old shadow even if a new write lands on the same edge.
    for (int i = 0; i < MEM_SIZE; i++) begin
      if (rel_v[i])  resp_d[i]   = shadow_q[i];
      if (wr_hit[i]) shadow_d[i] = wr_data;
    end
    pend_d = (pend_q & ~rel_v) | wr_hit;
    ovr_d  = |(wr_hit & pend_q & ~rel_v);
    err_d  = wr_acc && !wr_in_range;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEED_OPEN;
      wr_ready_q <= 1'b0;
      ovr_q      <= 1'b0;
      err_q      <= 1'b0;
      pend_q     <= '0;
      shadow_q   <= '0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ready_q <= 1'b1;
      ovr_q      <= ovr_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
      shadow_q   <= shadow_d;
      resp_q     <= resp_d;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign fresh_bits = fresh;
  assign read_resps = resp_q;
  assign ovr_pulse  = ovr_q;
  assign err_pulse  = err_q;

endmodule
